// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
package inst_fetch_queue_pkg;

    // Entry count of the instruction queue
    localparam int unsigned IQ_DEPTH = 8;

    // One lane carries {inst[31:0], pc[31:0]}
    localparam int unsigned LineIftToNextBusWidth = 64;
    localparam int unsigned IftToNextBusWidth     = 2 * LineIftToNextBusWidth;

    // Number of active lanes (0, 1 or 2) from two lane strobes
    function automatic logic [1:0] lane_count(input logic lane1, input logic lane2);
        return {1'b0, lane1} + {1'b0, lane2};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the dual-lane instruction queue.
module iq_ptr_ctrl
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lane1_valid_i,
    input  logic             lane2_valid_i,
    input  logic             deq_ready_i,
    input  logic             flush_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [PTR_W:0]   count_o,
    output logic             allowin_o,
    output logic             wr_lane1_o,
    output logic             wr_lane2_o,
    output logic             out_valid1_o,
    output logic             out_valid2_o,
    output logic             overflow_o
);

    // Two free slots are needed, so the largest count that still admits input is DEPTH-2
    localparam logic [PTR_W:0]   AllowMax = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W+1:0] DepthExt = (PTR_W + 2)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       n_enq, n_deq;
    logic [PTR_W+1:0] count_sum;

    // Enqueue/dequeue decisions and next pointer state; flush wins over everything
    always_comb begin
        allowin_o    = rst_n & (count_q <= AllowMax);
        out_valid1_o = (count_q != '0) & ~flush_i;
        out_valid2_o = (count_q > (PTR_W + 1)'(1)) & ~flush_i;
        wr_lane1_o   = allowin_o & ~flush_i & lane1_valid_i;
        // Lane 2 is only taken behind a valid lane 1
        wr_lane2_o   = wr_lane1_o & lane2_valid_i;
        n_enq        = lane_count(wr_lane1_o, wr_lane2_o);
        n_deq        = lane_count(out_valid1_o & deq_ready_i, out_valid2_o & deq_ready_i);
        count_sum    = {1'b0, count_q} + (PTR_W + 2)'(n_enq) - (PTR_W + 2)'(n_deq);
        overflow_o   = count_sum > DepthExt;
        // Pointer arithmetic wraps naturally since DEPTH is a power of two
        head_d       = head_q + PTR_W'(n_deq);
        tail_d       = tail_q + PTR_W'(n_enq);
        count_d      = count_sum[PTR_W:0];
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-lane in-order instruction buffer between fetch and decode.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = IQ_DEPTH,
    parameter int unsigned ENTRY_W = LineIftToNextBusWidth,
    parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line1_pre_to_now_valid_i,
    input  logic                 line2_pre_to_now_valid_i,
    input  logic [2*ENTRY_W-1:0] pre_to_ibus,
    output logic                 now_allowin_o,
    input  logic                 next_allowin_i,
    output logic                 line1_now_to_next_valid_o,
    output logic                 line2_now_to_next_valid_o,
    output logic [2*ENTRY_W-1:0] to_next_obus,
    input  logic                 excep_flush_i,
    input  logic                 branch_flush_i,
    output logic [PTR_W:0]       count_o,
    output logic                 error_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head, tail, head_p1, tail_p1;
    logic               flush, wr_lane1, wr_lane2, overflow;

    assign flush   = excep_flush_i | branch_flush_i;
    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    iq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .lane1_valid_i (line1_pre_to_now_valid_i),
        .lane2_valid_i (line2_pre_to_now_valid_i),
        .deq_ready_i   (next_allowin_i),
        .flush_i       (flush),
        .head_o        (head),
        .tail_o        (tail),
        .count_o       (count_o),
        .allowin_o     (now_allowin_o),
        .wr_lane1_o    (wr_lane1),
        .wr_lane2_o    (wr_lane2),
        .out_valid1_o  (line1_now_to_next_valid_o),
        .out_valid2_o  (line2_now_to_next_valid_o),
        .overflow_o    (overflow)
    );

    // Payload storage; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_lane1) begin
            mem_q[tail] <= pre_to_ibus[ENTRY_W-1:0];
        end
        if (wr_lane2) begin
            mem_q[tail_p1] <= pre_to_ibus[2*ENTRY_W-1:ENTRY_W];
        end
    end

    // Head-of-queue output lanes, zeroed when not valid so reset shows all-zero outputs
    always_comb begin
        to_next_obus = '0;
        if (line1_now_to_next_valid_o) begin
            to_next_obus[ENTRY_W-1:0] = mem_q[head];
        end
        if (line2_now_to_next_valid_o) begin
            to_next_obus[2*ENTRY_W-1:ENTRY_W] = mem_q[head_p1];
        end
    end

    // Protocol violation: orphan lane 2, or an occupancy update past DEPTH
    always_comb begin
        error_o = rst_n & ((line2_pre_to_now_valid_i & ~line1_pre_to_now_valid_i) | overflow);
    end

endmodule
